// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared CPU pipeline types: hazard FSM states and
// operand forwarding select codes.
package exe_hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/exe_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one source register.
// EXE results win over MEM; loads in EXE are not ready yet.
module fwd_unit
  import exe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] exe_wra_i,
  input  logic       exe_we_i,
  input  logic       exe_load_i,
  input  logic [4:0] mem_wra_i,
  input  logic       mem_we_i,
  output logic [1:0] sel_o
);

  logic exe_hit;
  logic mem_hit;

  assign exe_hit = exe_we_i && !exe_load_i &&
                   (exe_wra_i != 5'd0) &&
                   (src_i == exe_wra_i);
  assign mem_hit = mem_we_i &&
                   (mem_wra_i != 5'd0) &&
                   (src_i == mem_wra_i);

  always_comb begin
    sel_o = FWD_RF;
    if (exe_hit)      sel_o = FWD_EXE;
    else if (mem_hit) sel_o = FWD_MEM;
  end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage hazard control: load-use bubbles, multi-cycle
// ALU hold, operand forwarding and stall statistics.
module exe_hazard_ctrl
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULTI_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_useRs,
  input  logic        i_id_useRt,
  input  logic        i_id_multi,
  input  logic [4:0]  i_exe_WRA,
  input  logic        i_exe_regWe,
  input  logic        i_exe_isLoad,
  input  logic [4:0]  i_mem_WRA,
  input  logic        i_mem_regWe,
  input  logic        i_kill,
  output logic        o_pc_en,
  output logic        o_id_en,
  output logic        o_exe_en,
  output logic        o_exe_bubble,
  output logic [1:0]  o_fwdA,
  output logic [1:0]  o_fwdB,
  output logic        o_busy,
  output logic [15:0] o_stallCnt
);

  localparam logic [5:0] CNT_INIT = 6'(MULTI_LAT - 1);

  hz_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;
  logic        load_use;

  fwd_unit u_fwd_rs (
    .src_i      (i_id_rs),
    .exe_wra_i  (i_exe_WRA),
    .exe_we_i   (i_exe_regWe),
    .exe_load_i (i_exe_isLoad),
    .mem_wra_i  (i_mem_WRA),
    .mem_we_i   (i_mem_regWe),
    .sel_o      (o_fwdA)
  );

  fwd_unit u_fwd_rt (
    .src_i      (i_id_rt),
    .exe_wra_i  (i_exe_WRA),
    .exe_we_i   (i_exe_regWe),
    .exe_load_i (i_exe_isLoad),
    .mem_wra_i  (i_mem_WRA),
    .mem_we_i   (i_mem_regWe),
    .sel_o      (o_fwdB)
  );

  assign load_use = i_exe_regWe && i_exe_isLoad &&
                    (i_exe_WRA != 5'd0) &&
                    ((i_id_useRs && i_id_rs == i_exe_WRA) ||
                     (i_id_useRt && i_id_rt == i_exe_WRA));

  // A busy multi-cycle op holds everything; load-use waits for IDLE
  always_comb begin
    o_pc_en      = 1'b1;
    o_id_en      = 1'b1;
    o_exe_en     = 1'b1;
    o_exe_bubble = 1'b0;
    if (state_q == BUSY) begin
      o_pc_en  = 1'b0;
      o_id_en  = 1'b0;
      o_exe_en = 1'b0;
    end else if (load_use) begin
      o_pc_en      = 1'b0;
      o_id_en      = 1'b0;
      o_exe_bubble = 1'b1;
    end
  end

  assign o_busy     = (state_q == BUSY);
  assign o_stallCnt = stall_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_id_multi && o_id_en && !o_exe_bubble) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (i_kill || cnt_q == 6'd1) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!o_pc_en && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule
